// File: rtl/pipe_pkg.sv
// Shared pipeline types for the MEM stage and its neighbours (MEM/WB register, forwarding).
package pipe_pkg;

  // Width of the datapath carried in the MEM/WB record; must match the stage's DW.
  localparam int unsigned DATA_W = 32;

  // Register x0 is hardwired to zero and never written.
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWaitResp
  } mem_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [4:0]        writereg;
    logic              regwrite;
  } mem_wb_t;

  // Write enable is dropped for x0 and for any instruction that ended in an error.
  function automatic logic qual_regwrite(input logic regwrite, input logic [4:0] writereg,
                                         input logic err);
    return regwrite && (writereg != REG_ZERO) && !err;
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Response timeout counter: cleared on entry to the wait state, counts while enabled and
// flags expiry on the last permitted wait cycle.
module mem_timeout_ctr #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: performs the data-memory access for EX/MEM and produces the
// registered MEM/WB values with a one-cycle valid pulse per retired instruction.
module mem_stage
  import pipe_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned DW      = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] aluout_in,
  input  logic [DW-1:0] writedata_in,
  input  logic [4:0]    writereg_in,
  input  logic          memread_in,
  input  logic          memwrite_in,
  input  logic          regwrite_in,
  output logic          dmem_req_valid,
  input  logic          dmem_req_ready,
  output logic          dmem_req_we,
  output logic [DW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic          dmem_rvalid,
  input  logic [DW-1:0] dmem_rdata,
  output logic          wb_valid,
  output logic [DW-1:0] wb_result,
  output logic [4:0]    wb_writereg,
  output logic          wb_regwrite,
  output logic          misalign_err,
  output logic          bus_err
);

  mem_state_e    state_q, state_d;
  logic [DW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          we_q, we_d;
  logic [4:0]    wreg_q, wreg_d;
  logic          regwrite_q, regwrite_d;
  mem_wb_t       wb_q, wb_d;
  logic          wb_valid_q, wb_valid_d;
  logic          misalign_q, misalign_d;
  logic          bus_err_q, bus_err_d;

  logic ctr_clear, ctr_enable, ctr_expire;
  logic accept, is_memop, is_misaligned;

  assign in_ready      = (state_q == StIdle);
  assign accept        = in_valid && in_ready;
  assign is_memop      = memread_in || memwrite_in;
  assign is_misaligned = (aluout_in[1:0] != 2'b00);

  mem_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk_i    (clk),
    .rst_ni   (reset),
    .clear_i  (ctr_clear),
    .enable_i (ctr_enable),
    .expire_o (ctr_expire)
  );

  // Next-state, request latching and MEM/WB result selection.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    wreg_d     = wreg_q;
    regwrite_d = regwrite_q;
    wb_d       = wb_q;
    wb_valid_d = 1'b0;
    misalign_d = 1'b0;
    bus_err_d  = 1'b0;
    ctr_clear  = 1'b0;
    ctr_enable = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (!is_memop) begin
            wb_valid_d  = 1'b1;
            wb_d.result   = aluout_in;
            wb_d.writereg = writereg_in;
            wb_d.regwrite = qual_regwrite(regwrite_in, writereg_in, 1'b0);
          end else if (is_misaligned) begin
            wb_valid_d    = 1'b1;
            misalign_d    = 1'b1;
            wb_d.result   = aluout_in;
            wb_d.writereg = writereg_in;
            wb_d.regwrite = 1'b0;
          end else begin
            addr_d     = aluout_in;
            wdata_d    = writedata_in;
            // Load wins if both read and write are set.
            we_d       = memwrite_in && !memread_in;
            wreg_d     = writereg_in;
            regwrite_d = regwrite_in;
            state_d    = StReq;
          end
        end
      end

      StReq: begin
        if (dmem_req_ready) begin
          if (we_q) begin
            state_d       = StIdle;
            wb_valid_d    = 1'b1;
            wb_d.result   = addr_q;
            wb_d.writereg = wreg_q;
            wb_d.regwrite = 1'b0;
          end else begin
            state_d   = StWaitResp;
            ctr_clear = 1'b1;
          end
        end
      end

      StWaitResp: begin
        // A response arriving on the expiry cycle still completes the load normally.
        if (dmem_rvalid) begin
          state_d       = StIdle;
          wb_valid_d    = 1'b1;
          wb_d.result   = dmem_rdata;
          wb_d.writereg = wreg_q;
          wb_d.regwrite = qual_regwrite(regwrite_q, wreg_q, 1'b0);
        end else if (ctr_expire) begin
          state_d       = StIdle;
          wb_valid_d    = 1'b1;
          bus_err_d     = 1'b1;
          wb_d.result   = addr_q;
          wb_d.writereg = wreg_q;
          wb_d.regwrite = 1'b0;
        end else begin
          ctr_enable = 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // Stage state and MEM/WB registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      wreg_q     <= '0;
      regwrite_q <= 1'b0;
      wb_q       <= '0;
      wb_valid_q <= 1'b0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      wreg_q     <= wreg_d;
      regwrite_q <= regwrite_d;
      wb_q       <= wb_d;
      wb_valid_q <= wb_valid_d;
      misalign_q <= misalign_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign dmem_req_valid = (state_q == StReq);
  assign dmem_req_we    = we_q;
  assign dmem_addr      = addr_q;
  assign dmem_wdata     = wdata_q;

  assign wb_valid     = wb_valid_q;
  assign wb_result    = wb_q.result;
  assign wb_writereg  = wb_q.writereg;
  assign wb_regwrite  = wb_q.regwrite && wb_valid_q;
  assign misalign_err = misalign_q;
  assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: table of single-cycle ops plus directed
// store, load, timeout and reset sequences.
module tb_mem_stage;

  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned DW      = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] aluout_in;
  logic [DW-1:0] writedata_in;
  logic [4:0]    writereg_in;
  logic          memread_in;
  logic          memwrite_in;
  logic          regwrite_in;
  logic          dmem_req_valid;
  logic          dmem_req_ready;
  logic          dmem_req_we;
  logic [DW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic          dmem_rvalid;
  logic [DW-1:0] dmem_rdata;
  logic          wb_valid;
  logic [DW-1:0] wb_result;
  logic [4:0]    wb_writereg;
  logic          wb_regwrite;
  logic          misalign_err;
  logic          bus_err;

  int total = 0;
  int bad   = 0;

  mem_stage #(
    .TIMEOUT (TIMEOUT),
    .DW      (DW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .aluout_in      (aluout_in),
    .writedata_in   (writedata_in),
    .writereg_in    (writereg_in),
    .memread_in     (memread_in),
    .memwrite_in    (memwrite_in),
    .regwrite_in    (regwrite_in),
    .dmem_req_valid (dmem_req_valid),
    .dmem_req_ready (dmem_req_ready),
    .dmem_req_we    (dmem_req_we),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .dmem_rvalid    (dmem_rvalid),
    .dmem_rdata     (dmem_rdata),
    .wb_valid       (wb_valid),
    .wb_result      (wb_result),
    .wb_writereg    (wb_writereg),
    .wb_regwrite    (wb_regwrite),
    .misalign_err   (misalign_err),
    .bus_err        (bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu;
    logic [4:0]  wreg;
    logic        rd;
    logic        wr;
    logic        rw;
    logic        chk_res;
    logic [31:0] exp_res;
    logic        exp_rw;
    logic        exp_mis;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid     = 1'b0;
    aluout_in    = '0;
    writedata_in = '0;
    writereg_in  = '0;
    memread_in   = 1'b0;
    memwrite_in  = 1'b0;
    regwrite_in  = 1'b0;
  endtask

  // Aligned load with ready asserted; rvalid arrives dly cycles after the handshake.
  task automatic run_load(input logic [31:0] addr, input logic [4:0] wreg, input logic rw,
                          input int dly, input logic [31:0] rdata, input logic exp_rw);
    in_valid       = 1'b1;
    aluout_in      = addr;
    memread_in     = 1'b1;
    memwrite_in    = 1'b0;
    writereg_in    = wreg;
    regwrite_in    = rw;
    dmem_req_ready = 1'b1;
    dmem_rvalid    = 1'b0;
    tick();
    in_valid = 1'b0;
    check("ld_req_valid", 32'(dmem_req_valid), 32'd1);
    check("ld_req_we", 32'(dmem_req_we), 32'd0);
    check("ld_addr", dmem_addr, addr);
    tick();
    check("ld_wait_in_ready", 32'(in_ready), 32'd0);
    check("ld_wait_req_valid", 32'(dmem_req_valid), 32'd0);
    for (int i = 1; i < dly; i++) begin
      tick();
      check("ld_wait_no_wb", 32'(wb_valid), 32'd0);
    end
    dmem_rvalid = 1'b1;
    dmem_rdata  = rdata;
    tick();
    dmem_rvalid = 1'b0;
    check("ld_wb_valid", 32'(wb_valid), 32'd1);
    check("ld_wb_result", wb_result, rdata);
    check("ld_wb_writereg", 32'(wb_writereg), 32'(wreg));
    check("ld_wb_regwrite", 32'(wb_regwrite), 32'(exp_rw));
    check("ld_bus_err", 32'(bus_err), 32'd0);
    tick();
    check("ld_wb_pulse_end", 32'(wb_valid), 32'd0);
  endtask

  vec_t vecs[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic seen;

    vecs[0] = '{32'hDEADBEEF, 5'd31, 1'b0, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0};
    vecs[1] = '{32'h12345678, 5'd15, 1'b0, 1'b0, 1'b1, 1'b1, 32'h12345678, 1'b1, 1'b0};
    vecs[2] = '{32'h00000005, 5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 32'h00000005, 1'b0, 1'b0};
    vecs[3] = '{32'h00000203, 5'd7,  1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1};
    vecs[4] = '{32'h00000102, 5'd3,  1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1};
    vecs[5] = '{32'h00000001, 5'd2,  1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1};
    vecs[6] = '{32'hAAAA5555, 5'd1,  1'b0, 1'b0, 1'b0, 1'b1, 32'hAAAA5555, 1'b0, 1'b0};

    // Reset held with a pending load on the input.
    reset          = 1'b0;
    idle_inputs();
    in_valid       = 1'b1;
    aluout_in      = 32'h200;
    memread_in     = 1'b1;
    regwrite_in    = 1'b1;
    writereg_in    = 5'd5;
    dmem_req_ready = 1'b1;
    dmem_rvalid    = 1'b0;
    dmem_rdata     = '0;
    repeat (3) tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_req_valid", 32'(dmem_req_valid), 32'd0);
    check("rst_addr", dmem_addr, 32'd0);
    check("rst_wdata", dmem_wdata, 32'd0);
    check("rst_we", 32'(dmem_req_we), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_result", wb_result, 32'd0);
    check("rst_wb_writereg", 32'(wb_writereg), 32'd0);
    check("rst_wb_regwrite", 32'(wb_regwrite), 32'd0);
    check("rst_errs", {30'd0, misalign_err, bus_err}, 32'd0);
    idle_inputs();
    reset = 1'b1;
    tick();

    // Back-to-back single-cycle ops; a stray rvalid in IDLE must be ignored.
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hFFFF0000;
    in_valid    = 1'b1;
    aluout_in   = vecs[0].alu;
    writereg_in = vecs[0].wreg;
    memread_in  = vecs[0].rd;
    memwrite_in = vecs[0].wr;
    regwrite_in = vecs[0].rw;
    for (int i = 0; i < 7; i++) begin
      tick();
      check("tbl_wb_valid", 32'(wb_valid), 32'd1);
      check("tbl_in_ready", 32'(in_ready), 32'd1);
      check("tbl_req_valid", 32'(dmem_req_valid), 32'd0);
      check("tbl_writereg", 32'(wb_writereg), 32'(vecs[i].wreg));
      check("tbl_regwrite", 32'(wb_regwrite), 32'(vecs[i].exp_rw));
      check("tbl_misalign", 32'(misalign_err), 32'(vecs[i].exp_mis));
      check("tbl_bus_err", 32'(bus_err), 32'd0);
      if (vecs[i].chk_res) check("tbl_result", wb_result, vecs[i].exp_res);
      if (i < 6) begin
        aluout_in   = vecs[i+1].alu;
        writereg_in = vecs[i+1].wreg;
        memread_in  = vecs[i+1].rd;
        memwrite_in = vecs[i+1].wr;
        regwrite_in = vecs[i+1].rw;
      end else begin
        idle_inputs();
      end
    end
    dmem_rvalid = 1'b0;
    tick();
    check("tbl_wb_drop", 32'(wb_valid), 32'd0);
    check("tbl_hold_result", wb_result, 32'hAAAA5555);

    // Store held off by req_ready for 3 cycles; an ALU op waits behind it.
    dmem_req_ready = 1'b0;
    in_valid       = 1'b1;
    aluout_in      = 32'h100;
    writedata_in   = 32'hCAFEBABE;
    writereg_in    = 5'd4;
    memwrite_in    = 1'b1;
    memread_in     = 1'b0;
    regwrite_in    = 1'b0;
    tick();
    aluout_in    = 32'h00000077;
    writedata_in = 32'h0;
    writereg_in  = 5'd9;
    memwrite_in  = 1'b0;
    regwrite_in  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("st_req_valid", 32'(dmem_req_valid), 32'd1);
      check("st_addr", dmem_addr, 32'h100);
      check("st_wdata", dmem_wdata, 32'hCAFEBABE);
      check("st_we", 32'(dmem_req_we), 32'd1);
      check("st_in_ready", 32'(in_ready), 32'd0);
      check("st_no_wb", 32'(wb_valid), 32'd0);
      if (k == 3) dmem_req_ready = 1'b1;
      tick();
    end
    dmem_req_ready = 1'b0;
    check("st_wb_valid", 32'(wb_valid), 32'd1);
    check("st_wb_regwrite", 32'(wb_regwrite), 32'd0);
    check("st_wb_result", wb_result, 32'h100);
    check("st_req_drop", 32'(dmem_req_valid), 32'd0);
    check("st_in_ready_back", 32'(in_ready), 32'd1);
    tick();
    idle_inputs();
    check("wait_op_wb_valid", 32'(wb_valid), 32'd1);
    check("wait_op_result", wb_result, 32'h00000077);
    check("wait_op_writereg", 32'(wb_writereg), 32'd9);
    check("wait_op_regwrite", 32'(wb_regwrite), 32'd1);
    tick();
    check("st_single_pulse", 32'(wb_valid), 32'd0);

    // Loads: normal, and to x0.
    run_load(32'h200, 5'd5, 1'b1, 2, 32'h0BADF00D, 1'b1);
    run_load(32'h204, 5'd0, 1'b1, 1, 32'h11223344, 1'b0);

    // Misaligned load: no request, error pulse next cycle.
    in_valid    = 1'b1;
    aluout_in   = 32'h203;
    memread_in  = 1'b1;
    writereg_in = 5'd6;
    regwrite_in = 1'b1;
    #3;
    check("mis_no_req_same", 32'(dmem_req_valid), 32'd0);
    tick();
    idle_inputs();
    check("mis_no_req", 32'(dmem_req_valid), 32'd0);
    check("mis_wb_valid", 32'(wb_valid), 32'd1);
    check("mis_err", 32'(misalign_err), 32'd1);
    check("mis_regwrite", 32'(wb_regwrite), 32'd0);
    tick();

    // Timeout: no response, bus_err TIMEOUT cycles after entering WAIT_RESP.
    dmem_req_ready = 1'b1;
    in_valid       = 1'b1;
    aluout_in      = 32'h300;
    memread_in     = 1'b1;
    writereg_in    = 5'd8;
    regwrite_in    = 1'b1;
    tick();
    idle_inputs();
    tick();
    cyc  = 0;
    seen = 1'b0;
    for (int c = 1; c <= int'(TIMEOUT) + 4; c++) begin
      tick();
      if (wb_valid && !seen) begin
        seen = 1'b1;
        cyc  = c;
        check("to_bus_err", 32'(bus_err), 32'd1);
        check("to_regwrite", 32'(wb_regwrite), 32'd0);
        check("to_misalign", 32'(misalign_err), 32'd0);
      end
    end
    check("to_seen", 32'(seen), 32'd1);
    check("to_latency", 32'(cyc), 32'(TIMEOUT));
    check("to_idle", 32'(in_ready), 32'd1);

    // Reset during WAIT_RESP: access abandoned, no writeback pulse.
    in_valid    = 1'b1;
    aluout_in   = 32'h400;
    memread_in  = 1'b1;
    writereg_in = 5'd10;
    regwrite_in = 1'b1;
    tick();
    idle_inputs();
    repeat (3) tick();
    check("rm_in_wait", 32'(in_ready), 32'd0);
    #2;
    reset = 1'b0;
    #1;
    check("rm_in_ready", 32'(in_ready), 32'd1);
    check("rm_wb_valid", 32'(wb_valid), 32'd0);
    check("rm_req_valid", 32'(dmem_req_valid), 32'd0);
    tick();
    reset       = 1'b1;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h55555555;
    seen        = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      dmem_rvalid = 1'b0;
      if (wb_valid) seen = 1'b1;
    end
    check("rm_no_wb", 32'(seen), 32'd0);
    check("rm_idle", 32'(in_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage. Consumes the EX/MEM register outputs (ALU result, store data, destination register) and performs the data-memory access over a valid/ready request port with a separate response port.
- Produces the registered MEM/WB values (result, writereg, regwrite) with a one-cycle valid pulse per retired instruction.
- Back-pressures the EX/MEM register through in_ready while a memory access is outstanding.

Parameters:
- TIMEOUT, 16, maximum cycles spent in WAIT_RESP before a load is aborted with bus_err.
- DW, 32, data and address width.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- in_valid  in  1  EX/MEM holds a valid instruction.
- in_ready  out  1  stage accepts this cycle; equals (state==IDLE).
- aluout_in  in  DW  ALU result / effective address.
- writedata_in  in  DW  store data.
- writereg_in  in  5  destination register.
- memread_in  in  1  load.
- memwrite_in  in  1  store.
- regwrite_in  in  1  instruction writes the register file.
- dmem_req_valid  out  1  memory request valid.
- dmem_req_ready  in  1  memory accepts the request.
- dmem_req_we  out  1  1 = store.
- dmem_addr  out  DW  word-aligned address.
- dmem_wdata  out  DW  store data.
- dmem_rvalid  in  1  load data valid.
- dmem_rdata  in  DW  load data.
- wb_valid  out  1  one-cycle pulse; instruction retired into MEM/WB.
- wb_result  out  DW  load data or aluout.
- wb_writereg  out  5  destination register.
- wb_regwrite  out  1  qualified register-file write enable.
- misalign_err  out  1  pulse with wb_valid; memop address[1:0]!=0.
- bus_err  out  1  pulse with wb_valid; load timed out.

Behaviour:
- Reset (async, reset==0):
  - state=IDLE.
  - All registered outputs go to 0, including wb_*, the error pulses, dmem_req_valid, dmem_addr, dmem_wdata and dmem_req_we.
  - Timeout counter is cleared.
  - in_ready=1 while state is IDLE.
- Accept condition: in_valid && in_ready. Both memread_in and memwrite_in set is illegal and is treated as a load.
- Non-memory op (memread_in=0, memwrite_in=0):
  - Latency 1: next cycle wb_valid=1, wb_result=aluout_in.
  - State remains IDLE, so back-to-back throughput is 1 per cycle.
- Misaligned memop (aluout_in[1:0]!=0):
  - No memory request is issued.
  - Next cycle: wb_valid=1, misalign_err=1, wb_regwrite=0.
- Aligned memop:
  - On accept, latch the address, store data, writereg, regwrite and load/store type, then go to REQ.
  - In REQ: dmem_req_valid=1, driven from registers. dmem_addr, dmem_wdata and dmem_req_we are held stable until dmem_req_ready.
  - dmem_req_valid never drops before the handshake completes.
- REQ, on handshake (dmem_req_valid && dmem_req_ready):
  - Store: go to IDLE. Next cycle wb_valid=1, wb_regwrite=0, wb_result=the address.
  - Load: go to WAIT_RESP and clear the counter.
- WAIT_RESP:
  - dmem_rvalid=1: wb_result=dmem_rdata, wb_valid=1 next cycle, go to IDLE.
  - No response: the counter increments each cycle. When counter==TIMEOUT-1 with no rvalid, go to IDLE and pulse wb_valid=1, bus_err=1, wb_regwrite=0.
  - rvalid on the same cycle as timeout takes priority: treated as a normal load.
- dmem_rvalid outside WAIT_RESP is ignored.
- wb_regwrite = latched regwrite && (writereg!=0) && no error. It is 0 whenever wb_valid=0.
- wb_result and wb_writereg hold their last value between pulses.
- Reset mid-operation: the outstanding access is abandoned and no wb pulse is produced.
- The stage asserts in_ready only in IDLE. An upstream instruction presented during REQ or WAIT_RESP waits; it is never dropped.

Decomposition:
- Shared package pipe_pkg holds:
  - The state enum {IDLE, REQ, WAIT_RESP}.
  - Parameter REG_ZERO=5'd0.
  - A struct mem_wb_t {result, writereg, regwrite}, reusable by the mem_wb register and the forwarding unit.
- Sub-module mem_timeout_ctr: clear/enable/expire counter parameterised by TIMEOUT.

Test Plan:
- Reset held 0 with in_valid=1 → all outputs 0, in_ready=1, dmem_req_valid=0.
- ALU ops back-to-back: aluout 32'hDEADBEEF, writereg 31, regwrite=1, then 32'h12345678, writereg 15 → wb_valid on 2 consecutive cycles with those values, wb_regwrite=1, in_ready stays 1.
- Store to 32'h100, data 32'hCAFEBABE, with req_ready low for 3 cycles:
  - dmem_req_valid, addr and wdata are stable for 4 cycles.
  - in_ready=0 throughout.
  - One wb_valid pulse with wb_regwrite=0.
- Load from 32'h200 to writereg 5, rvalid 2 cycles after handshake with rdata 32'h0BADF00D → wb_result=32'h0BADF00D, wb_regwrite=1. A load to writereg 0 gives wb_regwrite=0.
- Misaligned load at 32'h203 → no dmem_req_valid, wb_valid with misalign_err=1 next cycle.
- Load with no rvalid → bus_err pulse TIMEOUT cycles after entering WAIT_RESP. A separate load run with reset asserted in WAIT_RESP → no wb_valid, state IDLE.
